// File: rtl/adc_osr_mc.sv
// Multi-channel OSR accumulator/decimator with a single-entry valid/ready output buffer.
// Optional build macro ADC_OSR_ROUND_EN selects round-half-up with saturation on right shifts.
module adc_osr_mc #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned CH_W     = 2,
  parameter int unsigned MAX_LOG4 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [CH_W-1:0]   ch_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [2:0]        osr_mode_in,
  input  logic              flush_in,
  output logic [OUT_W-1:0]  data_out,
  output logic [CH_W-1:0]   ch_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              overrun_out,
  input  logic              clr_ovr_in
);

  localparam int unsigned NUM_CH = 2 ** CH_W;
  localparam int unsigned ACC_W  = DATA_W + 2 * MAX_LOG4;
  localparam int unsigned CNT_W  = 2 * MAX_LOG4;
  localparam int unsigned CNTX_W = CNT_W + 1;
  localparam int unsigned WIDE_W = ACC_W + OUT_W + 1;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [2:0]       k_q [NUM_CH];

  logic [2:0]        k_lim;
  logic [2:0]        k_eff;
  logic [ACC_W-1:0]  acc_sum;
  logic [CNTX_W-1:0] cnt_next;
  logic              win_done;
  logic              res_valid;
  logic [WIDE_W-1:0] sum_w;
  logic [WIDE_W-1:0] res_w;
  logic [OUT_W-1:0]  res;
  int                sh;

  // Window bookkeeping for the channel addressed this cycle, plus result formatting.
  always_comb begin
    k_lim     = (osr_mode_in > 3'(MAX_LOG4)) ? 3'(MAX_LOG4) : osr_mode_in;
    k_eff     = (cnt[ch_in] == '0) ? k_lim : k_q[ch_in];
    acc_sum   = acc[ch_in] + ACC_W'(data_in);
    cnt_next  = CNTX_W'(cnt[ch_in]) + CNTX_W'(1);
    win_done  = (cnt_next == (CNTX_W'(1) << (2 * k_eff)));
    res_valid = ena && !flush_in && win_done;
    // Divide by 4**k (>>2k) and MSB-align to OUT_W (<<(OUT_W-DATA_W)) in one shift.
    sh        = int'(OUT_W) - int'(DATA_W) - 2 * int'(k_eff);
    sum_w     = WIDE_W'(acc_sum);
    res_w     = sum_w;
    if (sh >= 0) begin
      res_w = sum_w << sh;
    end else begin
`ifdef ADC_OSR_ROUND_EN
      res_w = (sum_w + (WIDE_W'(1) << (-sh - 1))) >> (-sh);
`else
      res_w = sum_w >> (-sh);
`endif
    end
    res = (|res_w[WIDE_W-1:OUT_W]) ? '1 : res_w[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
        k_q[i] <= '0;
      end
      data_out    <= '0;
      ch_out      <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (flush_in) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          acc[i] <= '0;
          cnt[i] <= '0;
        end
      end else if (ena) begin
        if (cnt[ch_in] == '0) k_q[ch_in] <= k_lim;
        if (win_done) begin
          acc[ch_in] <= '0;
          cnt[ch_in] <= '0;
        end else begin
          acc[ch_in] <= acc_sum;
          cnt[ch_in] <= cnt_next[CNT_W-1:0];
        end
      end

      // Output buffer: accept drains, a new result loads if there is room, else it is dropped.
      if (valid_out && ready_in) valid_out <= 1'b0;
      if (clr_ovr_in) overrun_out <= 1'b0;
      if (res_valid) begin
        if (!valid_out || ready_in) begin
          data_out  <= res;
          ch_out    <= ch_in;
          valid_out <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_osr_mc.sv
// Directed self-checking bench for adc_osr_mc with hand-computed expected results.
module tb_adc_osr_mc;

  logic        clk = 1'b0;
  logic        rst, ena, flush_in, ready_in, clr_ovr_in;
  logic [1:0]  ch_in;
  logic [11:0] data_in;
  logic [2:0]  osr_mode_in;
  logic [15:0] data_out;
  logic [1:0]  ch_out;
  logic        valid_out, overrun_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_rnd;

  adc_osr_mc dut (
    .clk(clk), .rst(rst), .ena(ena), .ch_in(ch_in), .data_in(data_in),
    .osr_mode_in(osr_mode_in), .flush_in(flush_in), .data_out(data_out),
    .ch_out(ch_out), .valid_out(valid_out), .ready_in(ready_in),
    .overrun_out(overrun_out), .clr_ovr_in(clr_ovr_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [1:0] ch, input logic [11:0] d);
    ena = 1'b1; ch_in = ch; data_in = d;
    tick();
    ena = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; flush_in = 1'b0; ready_in = 1'b1; clr_ovr_in = 1'b0;
    ch_in = '0; data_in = '0; osr_mode_in = 3'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_ch", 32'(ch_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_ovr", 32'(overrun_out), 32'h0);

    // k=0 pass-through, latency 1
    osr_mode_in = 3'd0;
    sample(2'd0, 12'h111);
    check("k0_v1", 32'(valid_out), 32'h1);
    check("k0_d1", 32'(data_out), 32'h1110);
    sample(2'd0, 12'h222);
    check("k0_v2", 32'(valid_out), 32'h1);
    check("k0_d2", 32'(data_out), 32'h2220);
    tick();
    check("k0_drain", 32'(valid_out), 32'h0);

    // k=1 on ch1: 0+1+2+3 = 6 -> 6<<2
    osr_mode_in = 3'd1;
    sample(2'd1, 12'd0); sample(2'd1, 12'd1); sample(2'd1, 12'd2);
    check("k1_early", 32'(valid_out), 32'h0);
    sample(2'd1, 12'd3);
    check("k1_v", 32'(valid_out), 32'h1);
    check("k1_d", 32'(data_out), 32'h0018);
    check("k1_ch", 32'(ch_out), 32'h1);
    tick();

    // k=2 interleaved ch0 ramp / ch2 constant
    osr_mode_in = 3'd2;
    for (int i = 0; i < 16; i++) begin
      sample(2'd0, 12'(12'h890 + i));
      if (i == 15) begin
        check("k2_ch0_d", 32'(data_out), 32'h8978);
        check("k2_ch0_c", 32'(ch_out), 32'h0);
      end
      sample(2'd2, 12'h890);
      if (i == 7) check("k2_mid", 32'(valid_out), 32'h0);
    end
    check("k2_ch2_d", 32'(data_out), 32'h8900);
    check("k2_ch2_c", 32'(ch_out), 32'h2);
    tick();

    // k=3 ramp 0..63 on ch3, k=4 ramp 0..255 on ch0
    osr_mode_in = 3'd3;
    for (int i = 0; i < 64; i++) sample(2'd3, 12'(i));
    check("k3_d", 32'(data_out), 32'h01F8);
    check("k3_v", 32'(valid_out), 32'h1);
    tick();
    osr_mode_in = 3'd4;
    for (int i = 0; i < 256; i++) sample(2'd0, 12'(i));
    check("k4_d", 32'(data_out), 32'h07F8);
    tick();

    // Rounding-sensitive: k=3, sum 2 -> 2>>2 truncates to 0, rounds to 1
    osr_mode_in = 3'd3;
    for (int i = 0; i < 63; i++) sample(2'd1, 12'd0);
    sample(2'd1, 12'd2);
`ifdef ADC_OSR_ROUND_EN
    exp_rnd = 32'h1;
`else
    exp_rnd = 32'h0;
`endif
    check("k3_round", 32'(data_out), exp_rnd);
    check("k3_round_v", 32'(valid_out), 32'h1);
    tick();

    // Back-pressure: second result dropped, overrun sticky, clear works, set beats clear
    osr_mode_in = 3'd0; ready_in = 1'b0;
    sample(2'd2, 12'h005);
    check("bp_d1", 32'(data_out), 32'h0050);
    sample(2'd3, 12'h006);
    check("bp_hold_d", 32'(data_out), 32'h0050);
    check("bp_hold_c", 32'(ch_out), 32'h2);
    check("bp_ovr", 32'(overrun_out), 32'h1);
    clr_ovr_in = 1'b1; tick(); clr_ovr_in = 1'b0;
    check("bp_clr", 32'(overrun_out), 32'h0);
    clr_ovr_in = 1'b1; sample(2'd3, 12'h007); clr_ovr_in = 1'b0;
    check("bp_setwins", 32'(overrun_out), 32'h1);
    clr_ovr_in = 1'b1; tick(); clr_ovr_in = 1'b0;
    ready_in = 1'b1; tick();
    check("bp_accept", 32'(valid_out), 32'h0);
    check("bp_ovr_off", 32'(overrun_out), 32'h0);

    // Mode change mid-window has no effect: k=1 window of 4 x 4 = 16 -> 0x40
    osr_mode_in = 3'd1;
    sample(2'd0, 12'd4); sample(2'd0, 12'd4);
    osr_mode_in = 3'd2;
    sample(2'd0, 12'd4);
    check("mode_early", 32'(valid_out), 32'h0);
    sample(2'd0, 12'd4);
    check("mode_v", 32'(valid_out), 32'h1);
    check("mode_d", 32'(data_out), 32'h0040);
    tick();

    // Flush after 3 samples, flush beats a simultaneous sample
    osr_mode_in = 3'd1;
    sample(2'd1, 12'h100); sample(2'd1, 12'h100); sample(2'd1, 12'h100);
    flush_in = 1'b1; sample(2'd1, 12'hFFF); flush_in = 1'b0;
    check("flush_nores", 32'(valid_out), 32'h0);
    sample(2'd1, 12'd1);
    check("flush_fresh", 32'(valid_out), 32'h0);
    sample(2'd1, 12'd1); sample(2'd1, 12'd1); sample(2'd1, 12'd1);
    check("flush_v", 32'(valid_out), 32'h1);
    check("flush_d", 32'(data_out), 32'h0010);
    tick();

    // Reset mid-window with a held result and overrun pending
    sample(2'd2, 12'd9); sample(2'd2, 12'd9);
    osr_mode_in = 3'd0; ready_in = 1'b0;
    sample(2'd3, 12'hABC);
    check("prerst_d", 32'(data_out), 32'hABC0);
    sample(2'd3, 12'h123);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_data", 32'(data_out), 32'h0);
    check("mrst_ch", 32'(ch_out), 32'h0);
    check("mrst_valid", 32'(valid_out), 32'h0);
    check("mrst_ovr", 32'(overrun_out), 32'h0);
    ready_in = 1'b1; osr_mode_in = 3'd1;
    sample(2'd2, 12'd1); sample(2'd2, 12'd1);
    check("mrst_abort", 32'(valid_out), 32'h0);
    sample(2'd2, 12'd1); sample(2'd2, 12'd1);
    check("mrst_new_d", 32'(data_out), 32'h0010);
    check("mrst_new_c", 32'(ch_out), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
